// File: rtl/dm_arbiter_pkg.sv
// dm_arbiter_pkg: shared types and defaults for the dm_arbiter slice.
//   - DEF_ADDR_W / DEF_DATA_W : default word-address and data widths of dm
//   - state_e                 : sequencer states (3-bit encoding)
//   - first_state()           : state entered from idle for a granted access
package dm_arbiter_pkg;

    localparam int unsigned DEF_ADDR_W = 16;
    localparam int unsigned DEF_DATA_W = 32;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StRd   = 3'd1,
        StWrHi = 3'd2,
        StWrLo = 3'd3,
        StAck  = 3'd4
    } state_e;

    function automatic state_e first_state(input logic we);
        return we ? StWrHi : StRd;
    endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if: requester-side bundle of the dm arbiter (both ports).
//   req0/req1     : access request, held until the matching ack
//   we0/we1       : 1 = store, 0 = load
//   addr0/addr1   : word address
//   wdata0/wdata1 : store data
//   gnt0/gnt1     : high while that port's access is in progress
//   ack0/ack1     : one-cycle completion pulse
//   rdata         : load data, valid in the ack cycle, shared by both ports
// Modports: master = requester side, slave = arbiter side.
interface dm_arbiter_if
    import dm_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
);

    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              ack0;
    logic              ack1;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  gnt0, gnt1, ack0, ack1, rdata
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output gnt0, gnt1, ack0, ack1, rdata
    );

endinterface

// File: rtl/dm_arb_pick.sv
// dm_arb_pick: combinational winner select for the dm arbiter.
//   req0/req1 : pending requests
//   last_gnt  : port granted most recently
//   win       : winning port index (meaningful only when a request is present)
// Build option DM_ARB_RR_EN: defined -> round-robin on ties (loser of the last
// grant wins); undefined -> fixed priority, port 0 always wins ties.
module dm_arb_pick (
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    output logic win
);

`ifdef DM_ARB_RR_EN
    always_comb begin
        win = 1'b0;
        if (req0 && req1) begin
            win = ~last_gnt;
        end else begin
            win = req1;
        end
    end
`else
    // last_gnt has no role under fixed priority; synthesis trims its source.
    logic unused_last_gnt;
    assign unused_last_gnt = last_gnt;

    always_comb begin
        win = 1'b0;
        if (!req0) begin
            win = req1;
        end
    end
`endif

endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port arbiter and access sequencer for the SISC data memory dm.
//   clk           : system clock, all state on rising edge
//   rst_f         : asynchronous active-low reset
//   bus           : requester bundle (dm_arbiter_if.slave), ports 0 and 1
//   dm_read_addr  : to dm read_addr, held outside loads
//   dm_write_addr : to dm write_addr, held outside stores
//   dm_write_data : to dm write_data, held outside stores
//   dm_we         : to dm; dm commits a write on the falling edge
//   dm_read_data  : from dm read_data
// Tie-break policy is chosen in dm_arb_pick by the DM_ARB_RR_EN macro.
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_f,
    dm_arbiter_if.slave       bus,
    output logic [ADDR_W-1:0] dm_read_addr,
    output logic [ADDR_W-1:0] dm_write_addr,
    output logic [DATA_W-1:0] dm_write_data,
    output logic              dm_we,
    input  logic [DATA_W-1:0] dm_read_data
);

    state_e            state_q, state_d;
    logic              cur_port_q;
    logic              last_gnt_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [ADDR_W-1:0] cur_addr_q;
    logic [DATA_W-1:0] cur_wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              dm_we_q;

    logic              win;
    logic              grant;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    dm_arb_pick u_pick (
        .req0     (bus.req0),
        .req1     (bus.req1),
        .last_gnt (last_gnt_q),
        .win      (win)
    );

    assign win_we    = win ? bus.we1    : bus.we0;
    assign win_addr  = win ? bus.addr1  : bus.addr0;
    assign win_wdata = win ? bus.wdata1 : bus.wdata0;

    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.req0 || bus.req1) begin
                    grant   = 1'b1;
                    state_d = first_state(win_we);
                end
            end
            StRd:    state_d = StAck;
            StWrHi:  state_d = StWrLo;
            StWrLo:  state_d = StAck;
            StAck:   state_d = StIdle;  // requests seen here are ignored
            default: state_d = StIdle;
        endcase
    end

    // dm_we is a flop so the strobe is glitch-free and drops the moment reset
    // asserts, which lets an interrupted store still commit.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q    <= StIdle;
            cur_port_q <= 1'b0;
            last_gnt_q <= 1'b1;
            rd_addr_q  <= '0;
            rdata_q    <= '0;
            dm_we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dm_we_q <= (state_d == StWrHi);
            if (grant) begin
                cur_port_q <= win;
                last_gnt_q <= win;
                if (!win_we) begin
                    rd_addr_q <= win_addr;
                end
            end
            if (state_q == StRd) begin
                rdata_q <= dm_read_data;
            end
        end
    end

    // Store address/data are not reset: an async reset mid-strobe must leave
    // them stable so dm's falling-edge commit sees the intended word. Loading
    // them only on store grants keeps the write lines quiet during loads.
    always_ff @(posedge clk) begin
        if (grant && win_we) begin
            cur_addr_q  <= win_addr;
            cur_wdata_q <= win_wdata;
        end
    end

    assign bus.gnt0  = (state_q != StIdle) && !cur_port_q;
    assign bus.gnt1  = (state_q != StIdle) &&  cur_port_q;
    assign bus.ack0  = (state_q == StAck)  && !cur_port_q;
    assign bus.ack1  = (state_q == StAck)  &&  cur_port_q;
    assign bus.rdata = rdata_q;

    assign dm_read_addr  = rd_addr_q;
    assign dm_write_addr = cur_addr_q;
    assign dm_write_data = cur_wdata_q;
    assign dm_we         = dm_we_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: self-checking bench for dm_arbiter with a dm memory stand-in,
// a transaction-level reference model, directed scenarios and random traffic.
module tb_dm_arbiter;
    import dm_arbiter_pkg::*;

    localparam int AW = 16;
    localparam int DW = 32;

    logic clk   = 1'b0;
    logic rst_f = 1'b0;
    always #5 clk = ~clk;

    dm_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    logic [AW-1:0] dm_read_addr;
    logic [AW-1:0] dm_write_addr;
    logic [DW-1:0] dm_write_data;
    logic          dm_we;
    logic [DW-1:0] dm_read_data;

    dm_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk           (clk),
        .rst_f         (rst_f),
        .bus           (bus),
        .dm_read_addr  (dm_read_addr),
        .dm_write_addr (dm_write_addr),
        .dm_write_data (dm_write_data),
        .dm_we         (dm_we),
        .dm_read_data  (dm_read_data)
    );

    // dm stand-in: asynchronous read, write committed on falling dm_we.
    logic [DW-1:0] mem     [0:65535];
    logic [DW-1:0] ref_mem [0:65535];

    assign dm_read_data = mem[dm_read_addr];

    always @(negedge dm_we) begin
        if (!$isunknown(dm_write_addr)) mem[dm_write_addr] <= dm_write_data;
    end

    int we_rise = 0;
    always @(posedge dm_we) we_rise++;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    // One access at a time: a load occupies 2 cycles after the grant edge
    // (access, ack), a store 3 (strobe high, strobe low, ack).
    bit            m_busy  = 1'b0;
    bit            m_port  = 1'b0;
    bit            m_we    = 1'b0;
    int            m_age   = 0;
    bit            m_last  = 1'b1;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_data  = '0;
    logic [AW-1:0] m_raddr = '0;
    logic [DW-1:0] m_rdata = '0;

    function automatic bit model_pick(input bit r0, input bit r1, input bit last);
        if (r0 && r1) begin
`ifdef DM_ARB_RR_EN
            return !last;
`else
            return 1'b0;
`endif
        end
        return r1;
    endfunction

    function automatic int model_len(input bit we);
        return we ? 3 : 2;
    endfunction

    always @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            // Reset during the strobe-high cycle still lands the store.
            if (m_busy && m_we && m_age == 0) ref_mem[m_addr] = m_data;
            m_busy  = 1'b0;
            m_last  = 1'b1;
            m_raddr = '0;
            m_rdata = '0;
        end else if (!m_busy) begin
            if (bus.req0 || bus.req1) begin
                m_port = model_pick(bus.req0, bus.req1, m_last);
                m_we   = m_port ? bus.we1    : bus.we0;
                m_addr = m_port ? bus.addr1  : bus.addr0;
                m_data = m_port ? bus.wdata1 : bus.wdata0;
                m_busy = 1'b1;
                m_age  = 0;
                m_last = m_port;
                if (!m_we) m_raddr = m_addr;
            end
        end else begin
            if (m_age == 0) begin
                if (m_we) ref_mem[m_addr] = m_data;
                else      m_rdata = ref_mem[m_addr];
            end
            if (m_age == model_len(m_we) - 1) m_busy = 1'b0;
            else                              m_age++;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic [4:0] exp_ctl;
        bool_ack_calc : begin
            bit is_ack;
            is_ack  = m_busy && (m_age == model_len(m_we) - 1);
            exp_ctl = {m_busy && !m_port, m_busy && m_port,
                       is_ack && !m_port, is_ack && m_port,
                       m_busy && m_we && m_age == 0};
        end
        check("ctl{gnt0,gnt1,ack0,ack1,we}",
              {bus.gnt0, bus.gnt1, bus.ack0, bus.ack1, dm_we}, exp_ctl);
        check("rdata", bus.rdata, m_rdata);
        check("dm_read_addr", dm_read_addr, m_raddr);
        if (m_busy && m_we) begin
            check("dm_write_addr", dm_write_addr, m_addr);
            check("dm_write_data", dm_write_data, m_data);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit port, input bit req, input bit we,
                         input logic [AW-1:0] addr, input logic [DW-1:0] data);
        if (port) begin
            bus.req1 = req; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = data;
        end else begin
            bus.req0 = req; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = data;
        end
    endtask

    // Counts negedges from the IDLE cycle in which the request is presented:
    // a load acks on the 3rd, a store on the 4th.
    task automatic wait_ack(input bit port, output int cycles);
        bit seen = 1'b0;
        cycles = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            cycles++;
            if (port ? bus.ack1 : bus.ack0) seen = 1'b1;
        end
        check("ack_seen", seen, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timed out");
    end

    initial begin
        int c;
        int pulses;
        bit order [4];
        bit a0, a1;

        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 32'hC0DE_0000 ^ 32'(i);
            ref_mem[i] = 32'hC0DE_0000 ^ 32'(i);
        end
        drive(0, 0, 0, '0, '0);
        drive(1, 0, 0, '0, '0);

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctl", {bus.gnt0, bus.gnt1, bus.ack0, bus.ack1, dm_we}, 5'b0);
        check("rst_rdata", bus.rdata, 32'h0);
        check("rst_raddr", dm_read_addr, 16'h0);
        rst_f = 1'b1;
        tick();

        // Single load from port 0.
        mem[16'h0005] = 32'h0000_00AA;
        ref_mem[16'h0005] = 32'h0000_00AA;
        drive(0, 1, 0, 16'h0005, '0);
        wait_ack(0, c);
        check("load_latency", c, 3);
        check("load_data", bus.rdata, 32'h0000_00AA);
        tick();
        bus.req0 = 1'b0;
        tick();

        // Port 1 store, then load back with req held.
        pulses = we_rise;
        drive(1, 1, 1, 16'h0010, 32'hDEAD_BEEF);
        wait_ack(1, c);
        check("store_latency", c, 4);
        check("store_pulses", we_rise - pulses, 1);
        check("store_mem", mem[16'h0010], 32'hDEAD_BEEF);
        tick();
        bus.we1 = 1'b0;
        wait_ack(1, c);
        check("reload_latency", c, 3);
        check("reload_data", bus.rdata, 32'hDEAD_BEEF);
        tick();
        bus.req1 = 1'b0;

        // Tie after reset, both loading and held continuously.
        rst_f = 1'b0;
        tick();
        rst_f = 1'b1;
        tick();
        drive(0, 1, 0, 16'h0003, '0);
        drive(1, 1, 0, 16'h0004, '0);
        for (int k = 0; k < 4; k++) begin
            bit seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                if (bus.ack0 || bus.ack1) begin
                    seen     = 1'b1;
                    order[k] = bus.ack1;
                end
            end
            check("tie_ack_seen", seen, 1);
        end
        check("tie_first", order[0], 0);
`ifdef DM_ARB_RR_EN
        check("tie_second", order[1], 1);
        check("tie_third", order[2], 0);
        check("tie_fourth", order[3], 1);
`else
        check("tie_second", order[1], 0);
        check("tie_third", order[2], 0);
        check("tie_fourth", order[3], 0);
`endif
        tick();
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        tick();

        // Back-to-back stores from port 0 with req held.
        pulses = we_rise;
        drive(0, 1, 1, 16'h0001, 32'h1111_1111);
        wait_ack(0, c);
        tick();
        bus.addr0  = 16'h0002;
        bus.wdata0 = 32'h2222_2222;
        wait_ack(0, c);
        check("b2b_latency", c, 4);
        tick();
        bus.req0 = 1'b0;
        check("b2b_pulses", we_rise - pulses, 2);
        check("b2b_mem1", mem[16'h0001], 32'h1111_1111);
        check("b2b_mem2", mem[16'h0002], 32'h2222_2222);
        tick();

        // Reset during the strobe-high cycle of a store.
        drive(0, 1, 1, 16'h0020, 32'h0000_1234);
        @(posedge clk);
        #2;
        check("wrhi_we", dm_we, 1);
        rst_f = 1'b0;
        #1;
        check("wrhi_rst_we", dm_we, 0);
        check("wrhi_rst_mem", mem[16'h0020], 32'h0000_1234);
        check("wrhi_rst_ctl", {bus.gnt0, bus.gnt1, bus.ack0, bus.ack1}, 4'b0);
        bus.req0 = 1'b0;
        tick();
        rst_f = 1'b1;
        tick();

        // Reset during a load access, then the next load is served.
        drive(0, 1, 0, 16'h0020, '0);
        @(posedge clk);
        #2;
        rst_f = 1'b0;
        #1;
        check("rd_rst_ack", bus.ack0, 0);
        check("rd_rst_rdata", bus.rdata, 32'h0);
        bus.req0 = 1'b0;
        tick();
        rst_f = 1'b1;
        tick();
        bus.req0 = 1'b1;
        wait_ack(0, c);
        check("post_rst_latency", c, 3);
        check("post_rst_data", bus.rdata, 32'h0000_1234);
        tick();
        bus.req0 = 1'b0;

        // Random traffic from both ports with occasional reset pulses.
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            a0 = bus.ack0;
            a1 = bus.ack1;
            @(posedge clk);
            #1;
            if (!bus.req0 || a0) begin
                if ($urandom_range(0, 2) != 0)
                    drive(0, 1, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), $urandom);
                else
                    bus.req0 = 1'b0;
            end
            if (!bus.req1 || a1) begin
                if ($urandom_range(0, 2) != 0)
                    drive(1, 1, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), $urandom);
                else
                    bus.req1 = 1'b0;
            end
            if ($urandom_range(0, 149) == 0) begin
                rst_f = 1'b0;
                #2;
                rst_f = 1'b1;
            end
        end
        tick();
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        repeat (5) tick();

        for (int a = 0; a < 64; a++) begin
            check($sformatf("mem[%0d]", a), mem[a], ref_mem[a]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
